// File: rtl/ux607_pwm8_fader_pkg.sv
// Shared types and sizing for the PWM duty-cycle fader.
// Channel count and compare width follow the 8-bit, 4-channel PWM core.
package ux607_pwm8_fader_pkg;

  localparam int PWM_NCH   = 4;
  localparam int PWM_CMP_W = 8;
  localparam int CH_W      = $clog2(PWM_NCH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    UPD,
    CHK
  } fade_state_e;

  typedef logic [PWM_CMP_W-1:0] cmp_t;

endpackage

// File: rtl/ux607_pwm8_fader_step.sv
// Saturating one-step move of a compare value toward its target.
// Arithmetic is done in 9 bits so the result never wraps past 0 or 255.
module ux607_pwm8_fader_step
  import ux607_pwm8_fader_pkg::*;
(
  input  cmp_t cur,
  input  cmp_t tgt,
  input  cmp_t s,
  output cmp_t nxt
);

  logic [PWM_CMP_W:0] sum;
  logic [PWM_CMP_W:0] dif;

  always_comb begin
    sum = {1'b0, cur} + {1'b0, s};
    dif = {1'b0, cur} - {1'b0, s};
    nxt = cur;
    if (cur < tgt) begin
      nxt = (sum > {1'b0, tgt}) ? tgt : sum[PWM_CMP_W-1:0];
    end else if (cur > tgt) begin
      // dif[MSB] set means cur - s went below zero
      nxt = (dif[PWM_CMP_W] || (dif[PWM_CMP_W-1:0] < tgt)) ? tgt : dif[PWM_CMP_W-1:0];
    end
  end

endmodule

// File: rtl/ux607_pwm8_fader.sv
// Duty-cycle fader: steps the four PWM compare values toward latched targets
// once every (div+1) PWM periods; host compare writes always pass through and win.
//
// state | meaning
// IDLE  | not fading, waiting for start
// WAIT  | counting PWM period ticks until the next update
// UPD   | writing one channel per cycle, ch 0..3
// CHK   | compare core read-back against targets; finish or wait again
module ux607_pwm8_fader
  import ux607_pwm8_fader_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       tgt_0,
  input  logic [7:0]       tgt_1,
  input  logic [7:0]       tgt_2,
  input  logic [7:0]       tgt_3,
  input  logic [7:0]       step,
  input  logic [DIV_W-1:0] div,
  input  logic             host_cmp_0_write_valid,
  input  logic [7:0]       host_cmp_0_write_bits,
  input  logic             host_cmp_1_write_valid,
  input  logic [7:0]       host_cmp_1_write_bits,
  input  logic             host_cmp_2_write_valid,
  input  logic [7:0]       host_cmp_2_write_bits,
  input  logic             host_cmp_3_write_valid,
  input  logic [7:0]       host_cmp_3_write_bits,
  input  logic [7:0]       cmp_0_read,
  input  logic [7:0]       cmp_1_read,
  input  logic [7:0]       cmp_2_read,
  input  logic [7:0]       cmp_3_read,
  input  logic             ip_0,
  output logic             cmp_0_write_valid,
  output logic [7:0]       cmp_0_write_bits,
  output logic             cmp_1_write_valid,
  output logic [7:0]       cmp_1_write_bits,
  output logic             cmp_2_write_valid,
  output logic [7:0]       cmp_2_write_bits,
  output logic             cmp_3_write_valid,
  output logic [7:0]       cmp_3_write_bits,
  output logic             busy,
  output logic             done_irq,
  output logic             conflict
);

  fade_state_e state, state_d;

  logic [PWM_NCH-1:0][PWM_CMP_W-1:0] tgt_in, tgt_q, cmp_rd, host_bits, wr_bits;
  logic [PWM_NCH-1:0]                host_valid, fad_valid, wr_valid;
  cmp_t                              step_q;
  logic [DIV_W-1:0]                  div_q, pcnt;
  logic [CH_W-1:0]                   ch;
  logic                              ip0_q, tick, all_match;
  cmp_t                              cur_sel, tgt_sel, step_nxt;

  assign tgt_in     = {tgt_3, tgt_2, tgt_1, tgt_0};
  assign cmp_rd     = {cmp_3_read, cmp_2_read, cmp_1_read, cmp_0_read};
  assign host_bits  = {host_cmp_3_write_bits, host_cmp_2_write_bits,
                       host_cmp_1_write_bits, host_cmp_0_write_bits};
  assign host_valid = {host_cmp_3_write_valid, host_cmp_2_write_valid,
                       host_cmp_1_write_valid, host_cmp_0_write_valid};

  // ip_0 rises once per PWM period on channel 0
  assign tick      = ip_0 & ~ip0_q;
  assign all_match = (cmp_rd == tgt_q);
  assign cur_sel   = cmp_rd[ch];
  assign tgt_sel   = tgt_q[ch];

  ux607_pwm8_fader_step u_step (
    .cur (cur_sel),
    .tgt (tgt_sel),
    .s   (step_q),
    .nxt (step_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = WAIT;
      WAIT:    if (tick && (pcnt == div_q)) state_d = UPD;
      UPD:     if (ch == CH_W'(PWM_NCH - 1)) state_d = CHK;
      CHK:     state_d = all_match ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    fad_valid = '0;
    wr_valid  = '0;
    wr_bits   = '0;
    for (int n = 0; n < PWM_NCH; n++) begin
      fad_valid[n] = (state == UPD) && (ch == CH_W'(n)) && !abort;
      wr_valid[n]  = host_valid[n] | fad_valid[n];
      wr_bits[n]   = host_valid[n] ? host_bits[n] : step_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ip0_q    <= 1'b0;
      tgt_q    <= '0;
      step_q   <= '0;
      div_q    <= '0;
      pcnt     <= '0;
      ch       <= '0;
      busy     <= 1'b0;
      done_irq <= 1'b0;
      conflict <= 1'b0;
    end else begin
      ip0_q    <= ip_0;
      done_irq <= 1'b0;
      if (|(host_valid & fad_valid)) conflict <= 1'b1;
      if (abort) begin
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            tgt_q    <= tgt_in;
            step_q   <= (step == '0) ? cmp_t'(1) : step;
            div_q    <= div;
            pcnt     <= '0;
            conflict <= 1'b0;
            busy     <= 1'b1;
          end
          WAIT: if (tick) begin
            if (pcnt == div_q) begin
              pcnt <= '0;
              ch   <= '0;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          UPD: ch <= ch + 1'b1;
          CHK: if (all_match) begin
            done_irq <= 1'b1;
            busy     <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmp_0_write_valid = wr_valid[0];
  assign cmp_1_write_valid = wr_valid[1];
  assign cmp_2_write_valid = wr_valid[2];
  assign cmp_3_write_valid = wr_valid[3];
  assign cmp_0_write_bits  = wr_bits[0];
  assign cmp_1_write_bits  = wr_bits[1];
  assign cmp_2_write_bits  = wr_bits[2];
  assign cmp_3_write_bits  = wr_bits[3];

endmodule

// File: tb/tb_ux607_pwm8_fader.sv
// Bench for the PWM fader: a small PWM-core register model closes the cmp loop,
// expected core writes are queued by stimulus and popped by a monitor.
module tb_ux607_pwm8_fader;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] val;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [3:0][7:0]  tgt   = '0;
  logic [7:0]       step  = '0;
  logic [7:0]       div   = '0;
  logic [3:0]       hv    = '0;
  logic [3:0][7:0]  hb    = '0;
  logic [3:0][7:0]  core  = '0;
  logic             ip_0  = 1'b0;
  logic [3:0]       wv;
  logic [3:0][7:0]  wb;
  logic             busy, done_irq, conflict;

  exp_t q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clock = ~clock;

  ux607_pwm8_fader #(.DIV_W(8)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .start                  (start),
    .abort                  (abort),
    .tgt_0                  (tgt[0]),
    .tgt_1                  (tgt[1]),
    .tgt_2                  (tgt[2]),
    .tgt_3                  (tgt[3]),
    .step                   (step),
    .div                    (div),
    .host_cmp_0_write_valid (hv[0]),
    .host_cmp_0_write_bits  (hb[0]),
    .host_cmp_1_write_valid (hv[1]),
    .host_cmp_1_write_bits  (hb[1]),
    .host_cmp_2_write_valid (hv[2]),
    .host_cmp_2_write_bits  (hb[2]),
    .host_cmp_3_write_valid (hv[3]),
    .host_cmp_3_write_bits  (hb[3]),
    .cmp_0_read             (core[0]),
    .cmp_1_read             (core[1]),
    .cmp_2_read             (core[2]),
    .cmp_3_read             (core[3]),
    .ip_0                   (ip_0),
    .cmp_0_write_valid      (wv[0]),
    .cmp_0_write_bits       (wb[0]),
    .cmp_1_write_valid      (wv[1]),
    .cmp_1_write_bits       (wb[1]),
    .cmp_2_write_valid      (wv[2]),
    .cmp_2_write_bits       (wb[2]),
    .cmp_3_write_valid      (wv[3]),
    .cmp_3_write_bits       (wb[3]),
    .busy                   (busy),
    .done_irq               (done_irq),
    .conflict               (conflict)
  );

  // PWM core compare registers: writes land one cycle after they are presented
  always @(posedge clock) begin
    for (int n = 0; n < 4; n++) if (wv[n]) core[n] <= wb[n];
  end

  always @(negedge clock) begin
    for (int n = 0; n < 4; n++) begin
      if (wv[n]) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL write_unexpected: ch%0d got 0x%02h, required no write", n, wb[n]);
        end else begin
          e = q.pop_front();
          if (e.ch == 2'(n) && e.val == wb[n]) n_pass++;
          else $display("FAIL write_value: got ch%0d=0x%02h, required ch%0d=0x%02h",
                        n, wb[n], e.ch, e.val);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic push(input int n, input logic [7:0] v);
    exp_t x;
    x.ch  = 2'(n);
    x.val = v;
    q.push_back(x);
  endtask

  task automatic exp4(input logic [7:0] a, b, c, d);
    push(0, a); push(1, b); push(2, c); push(3, d);
  endtask

  task automatic host_wr(input int n, input logic [7:0] v);
    push(n, v);
    @(posedge clock); #1;
    hv[n] = 1'b1; hb[n] = v;
    @(posedge clock); #1;
    hv[n] = 1'b0;
  endtask

  task automatic fade_start(input logic [7:0] t0, t1, t2, t3, st, dv);
    @(posedge clock); #1;
    tgt = {t3, t2, t1, t0}; step = st; div = dv; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("busy_after_start", busy, 1);
  endtask

  // One ip_0 rising edge at i=0, held high for `hold` cycles. Optional host
  // write of cmp2 at cycle host_at and abort+start pulse at cycle abort_at.
  task automatic do_tick(input int hold, input int host_at, input logic [7:0] host_val,
                         input int abort_at, output int done_at, output logic [63:0] busy_tr);
    done_at = -1;
    busy_tr = '0;
    for (int i = 0; i < hold + 10; i++) begin
      @(posedge clock); #1;
      ip_0  = (i < hold);
      hv[2] = (i == host_at);
      hb[2] = host_val;
      abort = (i == abort_at);
      start = (i == abort_at);
      @(negedge clock);
      if (done_irq && done_at < 0) done_at = i;
      if (i < 64) busy_tr[i] = busy;
    end
  endtask

  int          d;
  logic [63:0] bt;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_irq, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_valids", wv, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // ramp up on ch0, others already at target
    host_wr(0, 8'h00); host_wr(1, 8'h11); host_wr(2, 8'h22); host_wr(3, 8'h33);
    fade_start(8'h30, 8'h11, 8'h22, 8'h33, 8'h10, 8'd0);
    exp4(8'h10, 8'h11, 8'h22, 8'h33); do_tick(2, -1, 0, -1, d, bt); chk("up_done_p1", d, -1);
    exp4(8'h20, 8'h11, 8'h22, 8'h33); do_tick(2, -1, 0, -1, d, bt); chk("up_done_p2", d, -1);
    exp4(8'h30, 8'h11, 8'h22, 8'h33); do_tick(2, -1, 0, -1, d, bt); chk("up_done_p3", d, 6);
    chk("up_busy_end", busy, 0);
    chk("up_conflict", conflict, 0);

    // ramp down with underflow clamp on ch1
    host_wr(1, 8'hF0);
    fade_start(8'h30, 8'h05, 8'h22, 8'h33, 8'h40, 8'd0);
    exp4(8'h30, 8'hB0, 8'h22, 8'h33); do_tick(2, -1, 0, -1, d, bt); chk("dn_done_p1", d, -1);
    exp4(8'h30, 8'h70, 8'h22, 8'h33); do_tick(2, -1, 0, -1, d, bt); chk("dn_done_p2", d, -1);
    exp4(8'h30, 8'h30, 8'h22, 8'h33); do_tick(2, -1, 0, -1, d, bt); chk("dn_done_p3", d, -1);
    exp4(8'h30, 8'h05, 8'h22, 8'h33); do_tick(2, -1, 0, -1, d, bt); chk("dn_done_p4", d, 6);

    // overflow clamp: 0xF0 + 0x40 saturates at 0xFF
    host_wr(1, 8'hF0);
    fade_start(8'h30, 8'hFF, 8'h22, 8'h33, 8'h40, 8'd0);
    exp4(8'h30, 8'hFF, 8'h22, 8'h33); do_tick(2, -1, 0, -1, d, bt); chk("ovf_done", d, 6);

    // div=2: held-high ip_0 is a single tick, update only on the 3rd
    fade_start(8'h40, 8'hFF, 8'h22, 8'h33, 8'h10, 8'd2);
    do_tick(30, -1, 0, -1, d, bt); chk("div_t1", d, -1);
    do_tick(2, -1, 0, -1, d, bt);  chk("div_t2", d, -1);
    exp4(8'h40, 8'hFF, 8'h22, 8'h33); do_tick(2, -1, 0, -1, d, bt); chk("div_t3", d, 6);

    // host write collides with fader ch2 write
    fade_start(8'h40, 8'hFF, 8'h80, 8'h33, 8'h10, 8'd0);
    exp4(8'h40, 8'hFF, 8'h77, 8'h33); do_tick(2, 3, 8'h77, -1, d, bt);
    chk("cf_done_p1", d, -1);
    chk("cf_conflict", conflict, 1);
    exp4(8'h40, 8'hFF, 8'h80, 8'h33); do_tick(2, -1, 0, -1, d, bt);
    chk("cf_done_p2", d, 6);
    chk("cf_sticky", conflict, 1);

    // abort at ch1, with start in the same cycle
    fade_start(8'h40, 8'hFF, 8'h80, 8'h63, 8'h10, 8'd0);
    chk("ab_conflict_clr", conflict, 0);
    push(0, 8'h40); do_tick(2, -1, 0, 2, d, bt);
    chk("ab_busy_at", bt[2], 1);
    chk("ab_busy_after", bt[3], 0);
    chk("ab_done", d, -1);
    @(posedge clock); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    chk("ab_start_ign", busy, 0);
    do_tick(2, -1, 0, -1, d, bt);
    chk("ab_idle_busy", bt[11:0], 0);

    // step 0 behaves as 1
    fade_start(8'h40, 8'hFF, 8'h80, 8'h36, 8'h00, 8'd0);
    exp4(8'h40, 8'hFF, 8'h80, 8'h34); do_tick(2, -1, 0, -1, d, bt); chk("s0_p1", d, -1);
    exp4(8'h40, 8'hFF, 8'h80, 8'h35); do_tick(2, -1, 0, -1, d, bt); chk("s0_p2", d, -1);
    exp4(8'h40, 8'hFF, 8'h80, 8'h36); do_tick(2, -1, 0, -1, d, bt); chk("s0_p3", d, 6);

    // reset mid-WAIT, host pass-through while in reset
    fade_start(8'h40, 8'hFF, 8'h80, 8'h00, 8'h01, 8'd3);
    do_tick(2, -1, 0, -1, d, bt);
    chk("rw_busy_wait", bt[11], 1);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_valids", wv, 0);
    push(1, 8'h5A);
    hv[1] = 1'b1; hb[1] = 8'h5A;
    #1;
    chk("rw_pass_valid", wv[1], 1);
    chk("rw_pass_bits", wb[1], 8'h5A);
    @(posedge clock); #1;
    hv[1] = 1'b0;
    reset = 1'b0;
    do_tick(2, -1, 0, -1, d, bt);
    chk("rw_idle_busy", bt[11:0], 0);

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
